reg_file_32x64: RTL and testbench
=================================

// Module: reg_file_32x64
// PURPOSE
// - General-purpose register file for the LEG CPU datapath: 32 x 64-bit registers.
// - Two asynchronous read ports (operands A/B) and one synchronous write port (writeback).
// - Register 31 is the architectural zero register (XZR): reads return 0, writes are discarded.
// - Sits between decode (register selects) and ALU/writeback stages.
// PARAMETERS
// - DATA_W   64  width of each register and of all data ports
// - ADDR_W   5   select width; depth = 2**ADDR_W = 32
// - ZERO_REG 31  index hard-wired to zero
// PORTS
// - clk        in   1       single clock; all state updates on rising edge
// - rst        in   1       asynchronous, active-low reset
// - readRegA   in   ADDR_W  select for read port A
// - readRegB   in   ADDR_W  select for read port B
// - writeReg   in   ADDR_W  destination select for write port
// - writeData  in   DATA_W  data to be written
// - write      in   1       write enable, sampled on rising clk
// - readDataA  out  DATA_W  contents of regs[readRegA]
// - readDataB  out  DATA_W  contents of regs[readRegB]
// BEHAVIOUR
// - Storage: array named regs[0:31] of DATA_W bits, kept hierarchically probeable.
// - Reset: rst low -> all 32 registers cleared to 0 immediately, independent of clk.
// - Writes blocked while rst is low.
// - Reset outputs: readDataA = readDataB = 0 while rst is low.
// - Write: rising clk with rst high and write=1 -> regs[writeReg] <= writeData; 1-cycle latency.
// - write=0 -> no register changes.
// - writeReg==ZERO_REG -> write ignored; regs[31] stays 0.
// - Read: purely combinational, zero latency; output follows select/storage changes in same cycle.
// - readRegX==ZERO_REG -> readDataX = 0 regardless of storage.
// - A and B may select the same register; both return identical data.
// - Same-cycle read/write of one index: read returns old value until the edge (no forwarding)
//   unless the option below is compiled in.
// - rst asserted mid-operation: pending write lost, all registers zero.
// - On rst release, the first write takes effect on the next rising edge.
// - No X propagation: every select value 0..31 is legal.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined:
//   - write=1 and writeReg==readRegX (not ZERO_REG) -> readDataX = writeData
//     combinationally in the same cycle (write-through forwarding).
//   - Per port; rst low still forces 0.
// - Not defined: reads reflect storage only; new value visible after the rising edge.
// TESTING
// - Reset: write 64'hFFFF to r7, pulse rst low mid-cycle -> r7 and both outputs read 0
//   immediately, without waiting for a clk edge.
// - Write/read: write=1, writeReg=2, writeData=3, edge; then writeReg=5, writeData=4,
//   write=0, readRegB=2, edge -> readDataB=3; regs[5] stays 0.
// - Dual read: write 10 to r1, readRegA=2, readRegB=1 -> readDataA=3, readDataB=10.
// - Zero reg: write=1, writeReg=31, writeData=64'hDEAD_BEEF, edge; readRegB=31 -> readDataB=0;
//   regs[31]==0.
// - Same-cycle hazard: write=1, writeReg=4, writeData=9, readRegA=4 before edge ->
//   readDataA=0 without REGFILE_BYPASS_EN, 9 with it; after edge -> 9 in both builds.
// - Sweep: write {$random,$random} to r0..r30, read back on both ports -> exact match;
//   r31 reads 0.

Source files
------------

// File: rtl/reg_file_32x64_if.sv
// Register-file access bundle: two read selects/data and one write port.
// The master side (decode/writeback) drives selects and write data; the register file is the slave.
interface reg_file_32x64_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] readRegA;
    logic [ADDR_W-1:0] readRegB;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              write;
    logic [DATA_W-1:0] readDataA;
    logic [DATA_W-1:0] readDataB;

    modport master (
        output readRegA, readRegB, writeReg, writeData, write,
        input  readDataA, readDataB
    );

    modport slave (
        input  readRegA, readRegB, writeReg, writeData, write,
        output readDataA, readDataB
    );
endinterface

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous write port, XZR at r31.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file_32x64 #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input logic                clk,
    input logic                rst,
    reg_file_32x64_if.slave    bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [0:DEPTH-1];
    logic              wr_en;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Writes to the zero register are dropped here so its storage never leaves reset.
    assign wr_en = bus.write && (bus.writeReg != ZERO_SEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.writeReg] <= bus.writeData;
        end
    end

    always_comb begin
        rd_a = regs[bus.readRegA];
`ifdef REGFILE_BYPASS_EN
        if (bus.write && (bus.readRegA == bus.writeReg)) begin
            rd_a = bus.writeData;
        end
`endif
        if (!rst || (bus.readRegA == ZERO_SEL)) begin
            rd_a = '0;
        end
    end

    always_comb begin
        rd_b = regs[bus.readRegB];
`ifdef REGFILE_BYPASS_EN
        if (bus.write && (bus.readRegB == bus.writeReg)) begin
            rd_b = bus.writeData;
        end
`endif
        if (!rst || (bus.readRegB == ZERO_SEL)) begin
            rd_b = '0;
        end
    end

    assign bus.readDataA = rd_a;
    assign bus.readDataB = rd_b;
endmodule

// File: tb/tb_reg_file_32x64.sv
// Directed self-checking bench for reg_file_32x64: reset, write/read, dual read, XZR,
// same-cycle hazard (both build options) and a full sweep.
module tb_reg_file_32x64;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [63:0] exp_mem [0:30];

`ifdef REGFILE_BYPASS_EN
    localparam logic [63:0] HAZ_EXP = 64'd9;
`else
    localparam logic [63:0] HAZ_EXP = 64'd0;
`endif

    reg_file_32x64_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    reg_file_32x64 #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [4:0] idx, input logic [63:0] data);
        @(negedge clk);
        bus.write     = 1'b1;
        bus.writeReg  = idx;
        bus.writeData = data;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++;
        if (bus.readDataA !== 64'd0 || bus.readDataB !== 64'd0)
            $display("FAIL reset_out: A=%h B=%h expected 0", bus.readDataA, bus.readDataB);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        do_write(5'd7, 64'hFFFF);
        bus.readRegA = 5'd7;
        bus.readRegB = 5'd7;
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'hFFFF)
            $display("FAIL pre_reset_r7: got %h expected %h", bus.readDataA, 64'hFFFF);
        else pass_cnt++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (dut.regs[7] !== 64'd0)
            $display("FAIL async_reset_r7: got %h expected 0", dut.regs[7]);
        else pass_cnt++;
        total_cnt++;
        if (bus.readDataA !== 64'd0 || bus.readDataB !== 64'd0)
            $display("FAIL async_reset_out: A=%h B=%h expected 0", bus.readDataA, bus.readDataB);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        rst = 1'b1;
        do_write(5'd3, 64'h55);
        @(negedge clk);
        bus.write = 1'b1; bus.writeReg = 5'd3; bus.writeData = 64'h77;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (dut.regs[3] !== 64'd0)
            $display("FAIL reset_mid_write: r3=%h expected 0", dut.regs[3]);
        else pass_cnt++;
        rst = 1'b1;
        bus.readRegA = 5'd3;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'h77)
            $display("FAIL first_write_after_reset: got %h expected 77", bus.readDataA);
        else pass_cnt++;
        @(negedge clk);
        bus.write = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        bus.write = 1'b1; bus.writeReg = 5'd2; bus.writeData = 64'd3;
        @(negedge clk);
        bus.writeReg = 5'd5; bus.writeData = 64'd4; bus.write = 1'b0; bus.readRegB = 5'd2;
        #1;
        total_cnt++;
        if (bus.readDataB !== 64'd3)
            $display("FAIL write_read_r2: got %h expected 3", bus.readDataB);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dut.regs[5] !== 64'd0)
            $display("FAIL write_disabled_r5: got %h expected 0", dut.regs[5]);
        else pass_cnt++;
    endtask

    task automatic test_dual_read;
        do_write(5'd1, 64'd10);
        bus.readRegA = 5'd2;
        bus.readRegB = 5'd1;
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'd3 || bus.readDataB !== 64'd10)
            $display("FAIL dual_read: A=%h B=%h expected 3 and a", bus.readDataA, bus.readDataB);
        else pass_cnt++;
        bus.readRegA = 5'd1;
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'd10 || bus.readDataB !== 64'd10)
            $display("FAIL same_select: A=%h B=%h expected a", bus.readDataA, bus.readDataB);
        else pass_cnt++;
    endtask

    task automatic test_zero_reg;
        do_write(5'd31, 64'hDEAD_BEEF);
        bus.readRegB = 5'd31;
        #1;
        total_cnt++;
        if (bus.readDataB !== 64'd0)
            $display("FAIL zero_reg_read: got %h expected 0", bus.readDataB);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[31] !== 64'd0)
            $display("FAIL zero_reg_store: got %h expected 0", dut.regs[31]);
        else pass_cnt++;
    endtask

    task automatic test_hazard;
        @(negedge clk);
        bus.write = 1'b1; bus.writeReg = 5'd4; bus.writeData = 64'd9;
        bus.readRegA = 5'd4; bus.readRegB = 5'd1;
        #1;
        total_cnt++;
        if (bus.readDataA !== HAZ_EXP)
            $display("FAIL hazard_before_edge: got %h expected %h", bus.readDataA, HAZ_EXP);
        else pass_cnt++;
        total_cnt++;
        if (bus.readDataB !== 64'd10)
            $display("FAIL hazard_other_port: got %h expected a", bus.readDataB);
        else pass_cnt++;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'd9)
            $display("FAIL hazard_after_edge: got %h expected 9", bus.readDataA);
        else pass_cnt++;
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 31; i++) begin
            exp_mem[i] = {$urandom, $urandom};
            do_write(5'(i), exp_mem[i]);
        end
        for (int i = 0; i < 31; i++) begin
            bus.readRegA = 5'(i);
            bus.readRegB = 5'(30 - i);
            #1;
            total_cnt++;
            if (bus.readDataA !== exp_mem[i] || bus.readDataB !== exp_mem[30 - i])
                $display("FAIL sweep_r%0d: A=%h exp %h B=%h exp %h", i,
                         bus.readDataA, exp_mem[i], bus.readDataB, exp_mem[30 - i]);
            else pass_cnt++;
        end
        bus.readRegA = 5'd31;
        bus.readRegB = 5'd31;
        #1;
        total_cnt++;
        if (bus.readDataA !== 64'd0 || bus.readDataB !== 64'd0)
            $display("FAIL sweep_r31: A=%h B=%h expected 0", bus.readDataA, bus.readDataB);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst           = 1'b0;
        bus.write     = 1'b0;
        bus.writeReg  = '0;
        bus.writeData = '0;
        bus.readRegA  = '0;
        bus.readRegB  = '0;
        #12;
        test_reset;
        test_reset_mid_write;
        test_write_read;
        test_dual_read;
        test_zero_reg;
        test_hazard;
        test_sweep;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
